fp16_norm_pack: RTL

//  Output end of the half-precision FP adder datapath. The operand-ordering stage sits at the input
//  end and unpacks sign/exponent/mantissa. This block does the reverse. It takes the raw post-add

---
 rtl/fp16_norm_pack.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fp16_norm_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp16_norm_pack
// Description : Output stage of the binary16 adder. Normalizes the raw post-add
//               sign/exponent/mantissa one shift per cycle, then packs the word.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_norm_pack #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sgn,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+1:0]       in_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_zero,
    output logic                   out_ovf
);

    localparam int              c_res_w   = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W:0]  c_exp_max = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0]  c_exp_one = {{EXP_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_sgn;
    logic [EXP_W:0]       r_exp;
    logic [MAN_W+1:0]     r_mant;
    logic                 r_valid;
    logic [c_res_w-1:0]   r_result;
    logic                 r_zero;
    logic                 r_ovf;

    logic [EXP_W:0]       w_exp_inc;
    logic [EXP_W:0]       w_exp_dec;
    logic [MAN_W-1:0]     w_frac;

    // One bit of exponent headroom so a carry increment can be compared without wrap
    assign w_exp_inc = r_exp + c_exp_one;
    assign w_exp_dec = r_exp - c_exp_one;
    assign w_frac    = r_mant[MAN_W-1:0];

    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_ovf    = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sgn    <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sgn   <= in_sgn;
                        // A zero exponent carries the same scale as exponent one
                        r_exp   <= (in_exp == '0) ? c_exp_one : {1'b0, in_exp};
                        r_mant  <= in_mant;
                        r_state <= ST_NORM;
                    end
                end

                ST_NORM: begin
                    if (r_exp == c_exp_max) begin
                        r_result <= {r_sgn, r_exp[EXP_W-1:0], w_frac};
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_mant == '0) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_mant[MAN_W+1]) begin
                        r_mant <= r_mant >> 1;
                        r_exp  <= w_exp_inc;
                        if (w_exp_inc == c_exp_max) begin
                            r_result <= {r_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            r_ovf    <= 1'b1;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else if (r_mant[MAN_W]) begin
                        r_result <= {r_sgn, r_exp[EXP_W-1:0], w_frac};
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_exp <= c_exp_one) begin
                        r_result <= {r_sgn, {EXP_W{1'b0}}, w_frac};
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_mant <= r_mant << 1;
                        r_exp  <= w_exp_dec;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_zero  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
